// File: rtl/irq_ctrl.sv
// Prioritized interrupt controller: synchronizes peripheral lines, tracks
// pending/mask/trigger state and drives a registered hwint to the control unit.
`timescale 1ns/1ps
module irq_ctrl #(
  parameter int unsigned NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               cs,
  input  logic               rd,
  input  logic               wr,
  input  logic [1:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               hwint,
  input  logic               int_ack
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  logic [NUM_IRQ-1:0] s1_q, s2_q, s3_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] mask_q, trig_q;
  logic [4:0]         cur_id_q;
  state_t             state_q;
  logic               hwint_q;

  logic [NUM_IRQ-1:0] eligible, win_oh, w1c, ack_clr, rise;
  logic [4:0]         win_id;
  logic               wr_en, ack_take, eoi, in_service;

  assign wr_en      = cs & wr;
  assign eligible   = pend_q & mask_q;
  assign in_service = (state_q == SERVICE);
  assign ack_take   = (state_q == REQ) && int_ack && (|eligible);
  assign eoi        = wr_en && (addr == 2'd2) && (state_q == SERVICE);
  assign rise       = s2_q & ~s3_q;
  assign hwint      = hwint_q;

  // Lowest set bit of eligible is the winner; index found by scanning downward.
  always_comb begin
    win_id = '0;
    win_oh = eligible & (~eligible + NUM_IRQ'(1));
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (eligible[i-1]) win_id = 5'(i - 1);
    end
  end

  always_comb begin
    w1c     = (wr_en && (addr == 2'd0)) ? wdata[NUM_IRQ-1:0] : '0;
    ack_clr = ack_take ? win_oh : '0;
    // Edge bits: set has priority over W1C/ack clear; level bits mirror s2.
    pend_d  = (((pend_q & ~w1c & ~ack_clr) | rise) & trig_q) | (s2_q & ~trig_q);
  end

  function automatic logic [31:0] pad(input logic [NUM_IRQ-1:0] v);
    pad = '0;
    pad[NUM_IRQ-1:0] = v;
  endfunction

  always_comb begin
    rdata = '0;
    if (cs && rd) begin
      case (addr)
        2'd0: rdata = pad(pend_q);
        2'd1: rdata = pad(mask_q);
        2'd2: rdata = {in_service, 26'b0, cur_id_q};
        2'd3: rdata = pad(trig_q);
        default: rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      s3_q   <= '0;
      pend_q <= '0;
      mask_q <= '0;
      trig_q <= '0;
    end else begin
      s1_q   <= irq;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      pend_q <= pend_d;
      if (wr_en && (addr == 2'd1)) mask_q <= wdata[NUM_IRQ-1:0];
      if (wr_en && (addr == 2'd3)) trig_q <= wdata[NUM_IRQ-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      hwint_q  <= 1'b0;
      cur_id_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|eligible) begin
            state_q <= REQ;
            hwint_q <= 1'b1;
          end
        end
        REQ: begin
          if (!(|eligible)) begin
            state_q <= IDLE;
            hwint_q <= 1'b0;
          end else if (int_ack) begin
            cur_id_q <= win_id;
            state_q  <= SERVICE;
            hwint_q  <= 1'b0;
          end
        end
        SERVICE: begin
          if (eoi) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          hwint_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus queues expected {rdata, hwint} per
// register read; a negedge monitor pops and compares whenever cs&rd is seen.
`timescale 1ns/1ps
module tb_irq_ctrl;

  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_VEC  = 2'd2;
  localparam logic [1:0] A_TRIG = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  irq = '0;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        hwint;
  logic        int_ack = 1'b0;
  logic        done = 1'b0;

  string       q_name[$];
  logic [31:0] q_data[$];
  logic        q_hw[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  irq_ctrl #(.NUM_IRQ(8)) dut (
    .clk(clk), .rst(rst), .irq(irq), .cs(cs), .rd(rd), .wr(wr),
    .addr(addr), .wdata(wdata), .rdata(rdata), .hwint(hwint), .int_ack(int_ack)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cs && rd) begin
      n_tests++;
      if (q_data.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_read: rdata=%08h hwint=%b with no queued expectation", rdata, hwint);
      end else begin
        string       nm;
        logic [31:0] d;
        logic        h;
        nm = q_name.pop_front();
        d  = q_data.pop_front();
        h  = q_hw.pop_front();
        if (rdata !== d || hwint !== h) begin
          n_fail++;
          $display("FAIL %s: got rdata=%08h hwint=%b, expected rdata=%08h hwint=%b", nm, rdata, hwint, d, h);
        end
      end
    end
    if (done) begin
      n_tests++;
      if (q_data.size() != 0) begin
        n_fail++;
        $display("FAIL drain: %0d expectations never observed, expected 0", q_data.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    step();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_chk(input logic [1:0] a, input logic [31:0] d, input logic h, input string nm);
    q_name.push_back(nm); q_data.push_back(d); q_hw.push_back(h);
    cs = 1'b1; rd = 1'b1; addr = a;
    step();
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
  endtask

  initial begin
    step();
    rd_chk(A_PEND, 32'h0, 1'b0, "reset_pend");
    rd_chk(A_VEC,  32'h0, 1'b0, "reset_vec");
    rst = 1'b0;
    step();

    // Single edge source 0
    wr_reg(A_MASK, 32'h01);
    wr_reg(A_TRIG, 32'h01);
    irq = 8'h01;
    rd_chk(A_PEND, 32'h00, 1'b0, "edge_lat0");
    irq = 8'h00;
    rd_chk(A_PEND, 32'h00, 1'b0, "edge_lat1");
    rd_chk(A_PEND, 32'h00, 1'b0, "edge_lat2");
    rd_chk(A_PEND, 32'h01, 1'b0, "edge_pend_set");
    rd_chk(A_VEC,  32'h00, 1'b1, "edge_hwint");
    ack();
    rd_chk(A_VEC,  32'h8000_0000, 1'b0, "edge_vec_ack");
    rd_chk(A_PEND, 32'h00, 1'b0, "edge_pend_clr");
    wr_reg(A_VEC, 32'h0);
    rd_chk(A_VEC,  32'h0, 1'b0, "edge_eoi_vec");
    rd_chk(A_VEC,  32'h0, 1'b0, "edge_eoi_quiet");

    // Priority 2 beats 5
    wr_reg(A_MASK, 32'hFF);
    wr_reg(A_TRIG, 32'hFF);
    irq = 8'h24;
    rd_chk(A_PEND, 32'h00, 1'b0, "prio_lat0");
    irq = 8'h00;
    rd_chk(A_PEND, 32'h00, 1'b0, "prio_lat1");
    rd_chk(A_PEND, 32'h00, 1'b0, "prio_lat2");
    rd_chk(A_PEND, 32'h24, 1'b0, "prio_pend");
    rd_chk(A_PEND, 32'h24, 1'b1, "prio_hwint");
    ack();
    rd_chk(A_VEC,  32'h8000_0002, 1'b0, "prio_vec2");
    rd_chk(A_PEND, 32'h20, 1'b0, "prio_no_nest");
    wr_reg(A_VEC, 32'h0);
    rd_chk(A_VEC,  32'h2, 1'b0, "prio_eoi_idle");
    rd_chk(A_VEC,  32'h2, 1'b1, "prio_rereq");
    ack();
    rd_chk(A_VEC,  32'h8000_0005, 1'b0, "prio_vec5");
    rd_chk(A_PEND, 32'h00, 1'b0, "prio_pend_empty");
    wr_reg(A_VEC, 32'h0);
    rd_chk(A_VEC,  32'h5, 1'b0, "prio_eoi2");

    // Masking and W1C withdrawal in REQ
    wr_reg(A_TRIG, 32'h08);
    wr_reg(A_MASK, 32'h00);
    irq = 8'h08;
    rd_chk(A_PEND, 32'h00, 1'b0, "mask_lat0");
    irq = 8'h00;
    rd_chk(A_PEND, 32'h00, 1'b0, "mask_lat1");
    rd_chk(A_PEND, 32'h00, 1'b0, "mask_lat2");
    rd_chk(A_PEND, 32'h08, 1'b0, "mask_pend_only");
    rd_chk(A_PEND, 32'h08, 1'b0, "mask_no_hwint");
    wr_reg(A_MASK, 32'h08);
    rd_chk(A_MASK, 32'h08, 1'b0, "mask_wr1");
    rd_chk(A_VEC,  32'h5, 1'b1, "mask_hwint");
    wr_reg(A_PEND, 32'h08);
    rd_chk(A_PEND, 32'h00, 1'b1, "w1c_pend");
    rd_chk(A_PEND, 32'h00, 1'b0, "w1c_hwint_drop");
    ack();
    rd_chk(A_VEC,  32'h5, 1'b0, "ack_in_idle");

    // Level mode, deasserted before EOI
    wr_reg(A_TRIG, 32'h00);
    wr_reg(A_MASK, 32'h02);
    irq = 8'h02;
    rd_chk(A_PEND, 32'h00, 1'b0, "lvl_lat0");
    rd_chk(A_PEND, 32'h00, 1'b0, "lvl_lat1");
    rd_chk(A_PEND, 32'h00, 1'b0, "lvl_lat2");
    rd_chk(A_PEND, 32'h02, 1'b0, "lvl_pend");
    rd_chk(A_PEND, 32'h02, 1'b1, "lvl_hwint");
    ack();
    rd_chk(A_VEC,  32'h8000_0001, 1'b0, "lvl_vec");
    irq = 8'h00;
    rd_chk(A_PEND, 32'h02, 1'b0, "lvl_hold0");
    rd_chk(A_PEND, 32'h02, 1'b0, "lvl_hold1");
    rd_chk(A_PEND, 32'h02, 1'b0, "lvl_hold2");
    rd_chk(A_PEND, 32'h00, 1'b0, "lvl_drop");
    wr_reg(A_VEC, 32'h0);
    rd_chk(A_VEC,  32'h1, 1'b0, "lvl_eoi");
    rd_chk(A_VEC,  32'h1, 1'b0, "lvl_no_rereq");

    // Level mode, still asserted at EOI
    irq = 8'h02;
    rd_chk(A_PEND, 32'h00, 1'b0, "lvl2_lat0");
    rd_chk(A_PEND, 32'h00, 1'b0, "lvl2_lat1");
    rd_chk(A_PEND, 32'h00, 1'b0, "lvl2_lat2");
    rd_chk(A_PEND, 32'h02, 1'b1 ^ 1'b1, "lvl2_pend");
    rd_chk(A_PEND, 32'h02, 1'b1, "lvl2_hwint");
    ack();
    rd_chk(A_VEC,  32'h8000_0001, 1'b0, "lvl2_vec");
    wr_reg(A_VEC, 32'h0);
    rd_chk(A_VEC,  32'h1, 1'b0, "lvl2_eoi");
    rd_chk(A_VEC,  32'h1, 1'b1, "lvl2_rereq");
    ack();
    irq = 8'h00;
    repeat (4) step();
    wr_reg(A_VEC, 32'h0);
    rd_chk(A_PEND, 32'h00, 1'b0, "lvl2_clean");

    // Simultaneous edge set and W1C, EOI in IDLE
    wr_reg(A_TRIG, 32'h10);
    wr_reg(A_MASK, 32'h00);
    irq = 8'h10;
    rd_chk(A_PEND, 32'h00, 1'b0, "sim_lat0");
    rd_chk(A_PEND, 32'h00, 1'b0, "sim_lat1");
    wr_reg(A_PEND, 32'h10);
    rd_chk(A_PEND, 32'h10, 1'b0, "sim_set_wins");
    wr_reg(A_PEND, 32'h10);
    rd_chk(A_PEND, 32'h00, 1'b0, "sim_w1c_alone");
    wr_reg(A_VEC, 32'h0);
    rd_chk(A_VEC,  32'h1, 1'b0, "eoi_in_idle");
    irq = 8'h00;

    // Reset while in SERVICE with bit 4 pending
    wr_reg(A_TRIG, 32'h11);
    wr_reg(A_MASK, 32'h11);
    irq = 8'h11;
    rd_chk(A_PEND, 32'h00, 1'b0, "rst_lat0");
    irq = 8'h00;
    rd_chk(A_PEND, 32'h00, 1'b0, "rst_lat1");
    rd_chk(A_PEND, 32'h00, 1'b0, "rst_lat2");
    rd_chk(A_PEND, 32'h11, 1'b0, "rst_pend");
    rd_chk(A_VEC,  32'h1, 1'b1, "rst_hwint");
    ack();
    rd_chk(A_PEND, 32'h10, 1'b0, "rst_pre_pend");
    rd_chk(A_VEC,  32'h8000_0000, 1'b0, "rst_pre_vec");
    rst = 1'b1;
    rd_chk(A_VEC,  32'h0, 1'b0, "rst_async_vec");
    rd_chk(A_PEND, 32'h0, 1'b0, "rst_pend_clr");
    rd_chk(A_MASK, 32'h0, 1'b0, "rst_mask_clr");
    rd_chk(A_TRIG, 32'h0, 1'b0, "rst_trig_clr");
    rst = 1'b0;
    irq = 8'h10;
    rd_chk(A_PEND, 32'h00, 1'b0, "post_lat0");
    rd_chk(A_PEND, 32'h00, 1'b0, "post_lat1");
    rd_chk(A_PEND, 32'h00, 1'b0, "post_lat2");
    rd_chk(A_PEND, 32'h10, 1'b0, "post_pend_masked");
    rd_chk(A_PEND, 32'h10, 1'b0, "post_no_hwint");
    wr_reg(A_MASK, 32'h10);
    rd_chk(A_MASK, 32'h10, 1'b0, "post_mask_wr");
    rd_chk(A_MASK, 32'h10, 1'b1, "post_hwint");
    irq = 8'h00;

    done = 1'b1;
  end

endmodule
